// File: rtl/seq_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// elaboration-time sizing helpers.
package seq_adder_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  function automatic int unsigned calc_ndig(int unsigned width, int unsigned digit);
    return (digit == 0) ? 0 : width / digit;
  endfunction

  // Counter must be at least one bit wide even when a single digit covers WIDTH.
  function automatic int unsigned calc_cnt_w(int unsigned ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/seq_adder_fa_cell.sv
// One-bit full adder built from two half adders; DIGIT of these form the
// ripple chain that processes one digit per clock.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g_ab;
  logic g_pc;

  assign p    = a ^ b;
  assign g_ab = a & b;
  assign s    = p ^ cin;
  assign g_pc = p & cin;
  assign cout = g_ab | g_pc;

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits of each operand per clock
// through a full-adder chain, with the inter-digit carry held in a flip-flop.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = calc_cnt_w(NDIG);

  if (WIDTH < 2 || DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("seq_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] res_shift;
  logic             last_dig;

  assign chain[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (
      .a    (opa_q[i]),
      .b    (opb_q[i]),
      .cin  (chain[i]),
      .s    (dsum[i]),
      .cout (chain[i+1])
    );
  end

  // New digit enters at the top so the LSB digit ends up at bit 0 after NDIG shifts.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last_dig  = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // Subtraction is A + ~B + 1, the +1 riding in on the initial carry.
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        res_d   = res_shift;
        carry_d = chain[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_dig) begin
          sum_d   = res_shift;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: one instance with DIGIT=1 and one with
// DIGIT=4, checked against an integer-arithmetic reference model.
module tb_seq_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start1 = 1'b0, sub1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prev1 = '0;
  logic [7:0] prev4 = '0;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .sub   (sub1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .ovf   (ovf1)
  );

  seq_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .sub   (sub4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
  function automatic logic [9:0] model(input logic s, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, ures;
    int signed sa, sb, sres;
    logic c, o;
    logic [7:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      ures = ua + ub;
      c    = (ures > 255);
      sres = sa + sb;
    end else begin
      ures = ua - ub;
      c    = (ua >= ub);
      sres = sa - sb;
    end
    o = (sres > 127) || (sres < -128);
    r = 8'(ures);
    return {o, c, r};
  endfunction

  task automatic drive(input int w, input logic st, input logic s, input logic [7:0] a,
                       input logic [7:0] b);
    if (w == 1) begin
      start1 = st; sub1 = s; a1 = a; b1 = b;
    end else begin
      start4 = st; sub4 = s; a4 = a; b4 = b;
    end
  endtask

  task automatic observe(input int w, output logic bz, output logic dn, output logic [7:0] sm,
                         output logic co, output logic ov);
    if (w == 1) begin
      bz = busy1; dn = done1; sm = sum1; co = cout1; ov = ovf1;
    end else begin
      bz = busy4; dn = done4; sm = sum4; co = cout4; ov = ovf4;
    end
  endtask

  task automatic run_op(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input string tag);
    int ndig;
    logic [9:0] exp;
    logic [7:0] prev;
    logic bz, dn, co, ov;
    logic [7:0] sm;
    ndig = (w == 1) ? 8 : 2;
    exp  = model(s, a, b);
    prev = (w == 1) ? prev1 : prev4;
    @(negedge clk);
    drive(w, 1'b1, s, a, b);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < ndig; i++) begin
      observe(w, bz, dn, sm, co, ov);
      check({tag, ":busy"}, 32'(bz), 32'd1);
      check({tag, ":nodone"}, 32'(dn), 32'd0);
      check({tag, ":hold"}, 32'(sm), 32'(prev));
      @(posedge clk);
      #1;
    end
    observe(w, bz, dn, sm, co, ov);
    check({tag, ":done"}, 32'(dn), 32'd1);
    check({tag, ":busy_lo"}, 32'(bz), 32'd0);
    check({tag, ":sum"}, 32'(sm), 32'(exp[7:0]));
    check({tag, ":cout"}, 32'(co), 32'(exp[8]));
    check({tag, ":ovf"}, 32'(ov), 32'(exp[9]));
    if (w == 1) prev1 = exp[7:0];
    else        prev4 = exp[7:0];
  endtask

  task automatic check_zero(input int w, input string tag);
    logic bz, dn, co, ov;
    logic [7:0] sm;
    observe(w, bz, dn, sm, co, ov);
    check({tag, ":busy"}, 32'(bz), 32'd0);
    check({tag, ":done"}, 32'(dn), 32'd0);
    check({tag, ":sum"}, 32'(sm), 32'd0);
    check({tag, ":cout"}, 32'(co), 32'd0);
    check({tag, ":ovf"}, 32'(ov), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp;
    logic [9:0] expq[$];
    logic s;
    logic [7:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero(1, "rst1");
    check_zero(4, "rst4");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(1, 1'b0, 8'h7F, 8'h01, "add7f01");
    run_op(1, 1'b0, 8'hFF, 8'h01, "addff01");
    run_op(1, 1'b1, 8'h05, 8'h07, "sub0507");
    run_op(4, 1'b1, 8'h80, 8'h01, "sub8001");

    // Randomized operations on both widths of digit
    for (int i = 0; i < 12; i++) begin
      run_op(1, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)), "rnd1");
      run_op(4, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)), "rnd4");
    end

    // start pulsed during RUN must not disturb the operation in flight
    exp = model(1'b0, 8'h3C, 8'h55);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 8'h3C, 8'h55);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)));
      check("ign:busy", 32'(busy1), 32'd1);
      @(posedge clk);
      #1;
    end
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("ign:done", 32'(done1), 32'd1);
    check("ign:sum", 32'(sum1), 32'(exp[7:0]));
    check("ign:cout", 32'(cout1), 32'(exp[8]));
    check("ign:ovf", 32'(ovf1), 32'(exp[9]));
    prev1 = exp[7:0];
    @(posedge clk);
    #1;
    check("ign:idle_busy", 32'(busy1), 32'd0);
    check("ign:idle_done", 32'(done1), 32'd0);

    // start held high: accepted every NDIG+1 = 3 edges on the DIGIT=4 instance
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      s  = 1'($urandom_range(1));
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      drive(4, 1'b1, s, ra, rb);
      if (k % 3 == 0) expq.push_back(model(s, ra, rb));
      @(posedge clk);
      #1;
      if (k % 3 == 2) begin
        exp = expq.pop_front();
        check("hold:done", 32'(done4), 32'd1);
        check("hold:sum", 32'(sum4), 32'(exp[7:0]));
        check("hold:cout", 32'(cout4), 32'(exp[8]));
        check("hold:ovf", 32'(ovf4), 32'(exp[9]));
        prev4 = exp[7:0];
      end else begin
        check("hold:nodone", 32'(done4), 32'd0);
        check("hold:busy", 32'(busy4), 32'd1);
      end
    end
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during RUN cycle 4 aborts and clears outputs
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 8'hA5, 8'h3C);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("abort:busy_pre", 32'(busy1), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero(1, "abort1");
    check_zero(4, "abort4");
    @(negedge clk);
    rst = 1'b0;
    prev1 = '0;
    prev4 = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("abort:nodone", 32'(done1), 32'd0);
    end
    run_op(1, 1'b0, 8'h12, 8'h34, "post_rst1");
    run_op(4, 1'b1, 8'h10, 8'h20, "post_rst4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
# seq_adder

Parametrised multi-cycle adder/subtractor built from a chain of one-bit full-adder cells. It processes a WIDTH-bit operand pair DIGIT bits per clock, keeping the inter-digit carry in a flip-flop, so area scales with DIGIT rather than WIDTH. It uses a start/done handshake and is the arithmetic core for the lab datapath's multi-cycle ALU operations.

## Interface
- WIDTH, 8: operand and result width. Must be at least 2.
- DIGIT, 1: bits processed per clock. Must divide WIDTH exactly. Elaboration fails otherwise.
- Derived: NDIG = WIDTH/DIGIT, the number of digit cycles per operation.

- clk  in  1  clock. All registers update on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a new operation. Accepted only in IDLE or DONE.
- sub  in  1  0 = A+B, 1 = A−B. Sampled with start.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result registers valid.
- sum  out  WIDTH  result. Held until the next done.
- cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state = IDLE. busy, done, sum, cout and ovf are all 0. Internal shift registers, carry and digit counter are cleared.
- Start acceptance (IDLE or DONE, start=1):
  - Load opA = a and opB = b XOR {WIDTH{sub}}.
  - Set the carry flip-flop to sub.
  - Clear the counter to 0.
  - Go to RUN.
- start in RUN is ignored. The operands and sub already latched are unaffected.
- Each RUN cycle:
  - The DIGIT-cell ripple chain adds opA[DIGIT-1:0], opB[DIGIT-1:0] and the carry.
  - The DIGIT result bits shift into the top of the result register, which shifts right by DIGIT.
  - opA and opB shift right by DIGIT.
  - The carry register takes the chain's carry out.
  - The counter increments.
- On the last digit (counter = NDIG−1):
  - Record the carry into the MSB cell (internal carry of cell DIGIT−1 on the final digit) for ovf.
  - Go to DONE.
- DONE (one cycle):
  - done = 1.
  - sum, cout and ovf are updated on the edge entering DONE and are valid while done is high.
  - Next state: RUN if start=1, otherwise IDLE.
- sum, cout and ovf change only on the edge entering DONE. They hold through IDLE and through any following RUN.
- Arithmetic is modulo 2^WIDTH. There are no saturation modes.

## Timing
- Start accepted on edge E. busy is high for cycles E+1 … E+NDIG. done is high for cycle E+NDIG+1 only.
- Latency from start edge to done = NDIG+1 clocks. Example: WIDTH=8, DIGIT=1 gives 9. WIDTH=8, DIGIT=4 gives 3.
- Back-to-back: start asserted during the DONE cycle gives an issue interval of NDIG+1 clocks.
- busy and done are never high in the same cycle.
- rst overrides everything, including a start in the same cycle:
  - rst mid-RUN aborts the operation.
  - No done is produced.
  - Outputs return to 0 on the next edge.
- The DIGIT-bit chain is purely combinational between registers. The critical path is DIGIT full-adder carry stages.

## Structure
- Shared package seq_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a localparam function that computes NDIG and the counter width, $clog2(NDIG), minimum 1.
- Sub-module fa_cell: one-bit full adder with ports a, b, cin, s, cout, built from half-adder logic. It is instantiated DIGIT times in a generate loop to form the digit chain.
- Top level contains the FSM, counter, operand and result shift registers, and the carry flip-flop.

## Test plan
- WIDTH=8, DIGIT=1, add 0x7F+0x01 → sum=0x80, cout=0, ovf=1. done exactly 9 clocks after the start edge. busy high for 8 cycles.
- WIDTH=8, DIGIT=1, add 0xFF+0x01 → sum=0x00, cout=1, ovf=0. Then sub 0x05−0x07 → sum=0xFE, cout=0, ovf=0.
- WIDTH=8, DIGIT=4, sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1. done 3 clocks after start.
- start pulsed every cycle during RUN with different operands → only the first operation completes. Result is unchanged by the later operand values.
- start held high continuously → done pulses every NDIG+1 clocks. Each result matches the operands presented on its accepting edge.
- rst asserted at RUN cycle 4 → no done pulse, and all outputs are 0 from the next edge. A following start completes normally.
